// File: rtl/vid_pkg.sv
// Shared types and constants for the video timing back end: register layout,
// bus command codes, raster state encoding and the registered output bundle.
package vid_pkg;

   localparam int CW_DEF = 13;
   localparam int PW_DEF = 6;

   localparam logic [7:0] REG_CR   = 8'h00;
   localparam logic [7:0] REG_H1   = 8'h28;
   localparam logic [7:0] REG_H2   = 8'h30;
   localparam logic [7:0] REG_V1   = 8'h38;
   localparam logic [7:0] REG_V2   = 8'h40;
   localparam logic [7:0] REG_FIFO = 8'h48;
   localparam logic [7:0] REG_STAT = 8'h50;

   typedef enum logic [1:0] {
      CMD_NOP = 2'b00,
      CMD_RD  = 2'b01,
      CMD_WR  = 2'b10
   } bus_cmd_e;

   typedef struct packed {
      logic [CW_DEF-1:0] hend;
      logic [CW_DEF-1:0] hsize;
   } h1_t;

   typedef struct packed {
      logic [CW_DEF-1:0] hsync_end;
      logic [CW_DEF-1:0] hsync_start;
   } h2_t;

   typedef struct packed {
      logic [CW_DEF-1:0] vend;
      logic [CW_DEF-1:0] vsize;
   } v1_t;

   typedef struct packed {
      logic [CW_DEF-1:0] vsync_end;
      logic [CW_DEF-1:0] vsync_start;
   } v2_t;

   typedef struct packed {
      logic [PW_DEF-1:0] pcnt;
      logic              en;
   } cr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } vid_state_e;

   typedef struct packed {
      logic        hsync;
      logic        hblank;
      logic        vsync;
      logic        vblank;
      logic [23:0] rgb;
      logic        frame_start;
      logic        underflow;
   } vid_out_t;

   localparam vid_out_t OUT_RST = '{hsync: 1'b0, hblank: 1'b1, vsync: 1'b0, vblank: 1'b1,
                                    rgb: 24'h0, frame_start: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/vid_pix_div.sv
// Programmable pixel-tick divider: one tick every pcnt+1 enabled clocks,
// held at zero while cleared.
module vid_pix_div
   import vid_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic          clr_i,
   input  logic [PW-1:0] pcnt_i,
   output logic          tick_o
);

   logic [PW-1:0] cnt_q, cnt_d;

   // >= rather than == keeps the count in range if pcnt shrinks while running.
   assign tick_o = en_i && !clr_i && (cnt_q >= pcnt_i);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + PW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vid_timing_out.sv
// Raster timing generator and pixel output stage: pops the pixel FIFO during
// active video and drives registered sync, blank and RGB to the display.
module vid_timing_out
   import vid_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [PW-1:0] pcnt,
   input  logic [CW-1:0] hsize,
   input  logic [CW-1:0] hend,
   input  logic [CW-1:0] hsync_start,
   input  logic [CW-1:0] hsync_end,
   input  logic [CW-1:0] vsize,
   input  logic [CW-1:0] vend,
   input  logic [CW-1:0] vsync_start,
   input  logic [CW-1:0] vsync_end,
   input  logic [23:0]   fifo_rdata,
   input  logic          fifo_empty,
   output logic          fifo_rd,
   output logic          hsync,
   output logic          hblank,
   output logic          vsync,
   output logic          vblank,
   output logic [7:0]    R,
   output logic [7:0]    G,
   output logic [7:0]    B,
   output logic          frame_start,
   output logic          underflow
);

   vid_state_e    state_q, state_d;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] vcnt_q, vcnt_d;
   vid_out_t      out_q, out_d;

   logic          run, tick;
   logic [CW-1:0] hend_m1, vend_m1;
   logic [CW-1:0] h_nxt, v_nxt;
   logic          h_last, v_last, frame_end;
   logic          advance, next_active;

   assign run = (state_q == RUN);

   vid_pix_div #(.PW(PW)) u_div (
      .clk    (clk),
      .reset  (reset),
      .en_i   (run),
      .clr_i  (!run),
      .pcnt_i (pcnt),
      .tick_o (tick)
   );

   // A zero end value behaves as one, so the counters always have a wrap point.
   assign hend_m1   = (hend == '0) ? '0 : hend - CW'(1);
   assign vend_m1   = (vend == '0) ? '0 : vend - CW'(1);
   assign h_last    = (hcnt_q >= hend_m1);
   assign v_last    = (vcnt_q >= vend_m1);
   assign frame_end = h_last && v_last;

   // Leaving PRIME enters (0,0) directly, so that edge is treated like a tick.
   always_comb begin
      h_nxt = '0;
      v_nxt = '0;
      if (run) begin
         h_nxt = h_last ? '0 : hcnt_q + CW'(1);
         v_nxt = !h_last ? vcnt_q : (v_last ? '0 : vcnt_q + CW'(1));
      end
   end

   assign advance     = ((state_q == PRIME) && !fifo_empty) ||
                        (run && tick && (enable || !frame_end));
   assign next_active = (h_nxt < hsize) && (v_nxt < vsize);
   assign fifo_rd     = advance && next_active && !fifo_empty;

   always_comb begin
      state_d           = state_q;
      hcnt_d            = hcnt_q;
      vcnt_d            = vcnt_q;
      out_d             = out_q;
      out_d.frame_start = 1'b0;

      unique case (state_q)
         IDLE: begin
            out_d           = OUT_RST;
            out_d.underflow = out_q.underflow;
            hcnt_d          = '0;
            vcnt_d          = '0;
            if (enable) begin
               state_d         = PRIME;
               out_d.underflow = 1'b0;
            end
         end
         PRIME: begin
            if (!fifo_empty) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (tick && frame_end && !enable) begin
               state_d         = IDLE;
               out_d           = OUT_RST;
               out_d.underflow = out_q.underflow;
               hcnt_d          = '0;
               vcnt_d          = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         hcnt_d            = h_nxt;
         vcnt_d            = v_nxt;
         out_d.hblank      = !(h_nxt < hsize);
         out_d.vblank      = !(v_nxt < vsize);
         out_d.hsync       = (h_nxt >= hsync_start) && (h_nxt < hsync_end);
         out_d.vsync       = (v_nxt >= vsync_start) && (v_nxt < vsync_end);
         out_d.rgb         = fifo_rd ? fifo_rdata : 24'h0;
         out_d.frame_start = (h_nxt == '0) && (v_nxt == '0);
         if (next_active && fifo_empty) begin
            out_d.underflow = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         out_q   <= OUT_RST;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         out_q   <= out_d;
      end
   end

   assign hsync       = out_q.hsync;
   assign hblank      = out_q.hblank;
   assign vsync       = out_q.vsync;
   assign vblank      = out_q.vblank;
   assign R           = out_q.rgb[23:16];
   assign G           = out_q.rgb[15:8];
   assign B           = out_q.rgb[7:0];
   assign frame_start = out_q.frame_start;
   assign underflow   = out_q.underflow;

endmodule

// File: tb/tb_vid_timing_out.sv
// Directed bench for vid_timing_out: a small FIFO model feeds pixels, a
// scoreboard queue holds the expected pixel order, and a raster model checks timing.
module tb_vid_timing_out;

   localparam int CW = 13;
   localparam int PW = 6;

   // {hsync, hblank, vsync, vblank, frame_start, underflow, popped, rgb}
   localparam logic [30:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};

   logic          clk = 1'b0;
   logic          reset, enable;
   logic [PW-1:0] pcnt;
   logic [CW-1:0] hsize, hend, hsync_start, hsync_end;
   logic [CW-1:0] vsize, vend, vsync_start, vsync_end;
   logic [23:0]   fifo_rdata;
   logic          fifo_empty, fifo_rd;
   logic          hsync, hblank, vsync, vblank, frame_start, underflow;
   logic [7:0]    R, G, B;

   logic [23:0]   mem [64];
   logic [5:0]    wr_ptr = '0;
   logic [5:0]    rd_ptr = '0;
   logic          pop_q  = 1'b0;

   logic [23:0]   exp_q [$];
   logic [23:0]   last_pix = '0;
   int            vectors = 0;
   int            fails   = 0;
   int            cyc     = 0;
   int            pops    = 0;
   int            word    = 1;

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_rdata = mem[rd_ptr];

   always @(posedge clk) begin
      pop_q <= fifo_rd;
      if (fifo_rd) rd_ptr <= rd_ptr + 6'd1;
   end

   vid_timing_out #(.CW(CW), .PW(PW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .pcnt        (pcnt),
      .hsize       (hsize),
      .hend        (hend),
      .hsync_start (hsync_start),
      .hsync_end   (hsync_end),
      .vsize       (vsize),
      .vend        (vend),
      .vsync_start (vsync_start),
      .vsync_end   (vsync_end),
      .fifo_rdata  (fifo_rdata),
      .fifo_empty  (fifo_empty),
      .fifo_rd     (fifo_rd),
      .hsync       (hsync),
      .hblank      (hblank),
      .vsync       (vsync),
      .vblank      (vblank),
      .R           (R),
      .G           (G),
      .B           (B),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = 24'(word);
         exp_q.push_back(24'(word));
         wr_ptr = wr_ptr + 6'd1;
         word++;
      end
   endtask

   function automatic logic [30:0] obs_vec();
      return {hsync, hblank, vsync, vblank, frame_start, underflow, pop_q, R, G, B};
   endfunction

   // Advance to the next falling edge; any pop on the last rising edge must show the next queued word.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (pop_q) begin
         pops++;
         if (exp_q.size() == 0) begin
            chk("sb_empty", 64'(exp_q.size()), 64'd1);
         end else begin
            last_pix = exp_q.pop_front();
            chk("pix", 64'({R, G, B}), 64'(last_pix));
         end
      end
   endtask

   // Raster of 6x3 positions with a 4x2 active window, hsync at h=4, vsync on line 2.
   task automatic check_raster(input int n, input int pd, input int drop_c, input int uf_c);
      for (int c = 0; c < n; c++) begin
         int          pix, h, v;
         logic        act, starved;
         logic [30:0] e;
         step();
         pix     = c / pd;
         h       = pix % 6;
         v       = (pix / 6) % 3;
         act     = (h < 4) && (v < 2);
         starved = (c == uf_c);
         e = {h == 4, h >= 4, v == 2, v >= 2, (c % (18 * pd)) == 0,
              (uf_c >= 0) && (c >= uf_c), act && !starved && ((c % pd) == 0),
              (act && !starved) ? last_pix : 24'h0};
         chk("raster", 64'(obs_vec()), 64'(e));
         if (c == drop_c) enable = 1'b0;
         if (starved) push(1);
      end
   endtask

   initial begin
      int p0;
      reset       = 1'b1;
      enable      = 1'b0;
      pcnt        = '0;
      hsize       = 13'd4;
      hend        = 13'd6;
      hsync_start = 13'd4;
      hsync_end   = 13'd5;
      vsize       = 13'd2;
      vend        = 13'd3;
      vsync_start = 13'd2;
      vsync_end   = 13'd3;

      step();
      chk("reset", 64'(obs_vec()), 64'(RST_VEC));
      reset = 1'b0;
      step();
      step();
      chk("idle", 64'(obs_vec()), 64'(RST_VEC));

      // Three frames at one clock per pixel, enable dropped at (1,0) of the third.
      push(24);
      enable = 1'b1;
      step();
      chk("prime1", 64'(obs_vec()), 64'(RST_VEC));
      check_raster(54, 1, 37, -1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stop1", 64'(obs_vec()), 64'(RST_VEC));
      end
      chk("pops1", 64'(pops), 64'd24);

      // One frame at three clocks per pixel.
      pcnt = 6'd2;
      push(8);
      p0     = pops;
      enable = 1'b1;
      step();
      chk("prime2", 64'(obs_vec()), 64'(RST_VEC));
      check_raster(54, 3, 3, -1);
      step();
      chk("stop2", 64'(obs_vec()), 64'(RST_VEC));
      chk("pops2", 64'(pops - p0), 64'd8);

      // FIFO runs dry at (2,1); one word returns for (3,1).
      pcnt = 6'd0;
      push(6);
      enable = 1'b1;
      step();
      chk("prime3", 64'(obs_vec()), 64'(RST_VEC));
      check_raster(18, 1, 9, 8);
      step();
      chk("stop3", 64'({hsync, hblank, vsync, vblank, frame_start, pop_q, R, G, B}),
          64'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0}));

      // Enable with an empty FIFO: hold in PRIME, underflow cleared, no raster.
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("prime_wait", 64'(obs_vec()), 64'(RST_VEC));
      end
      push(1);
      step();
      chk("fs_after_data", 64'({frame_start, hblank, vblank}), 64'(3'b100));

      // Starve two pixels, then assert reset between clock edges.
      step();
      step();
      chk("uf_before_reset", 64'(underflow), 64'd1);
      #2 reset = 1'b1;
      #1 chk("async_reset", 64'(obs_vec()), 64'(RST_VEC));
      step();
      step();
      chk("reset_hold", 64'(obs_vec()), 64'(RST_VEC));
      push(8);
      reset = 1'b0;
      step();
      chk("prime5", 64'(obs_vec()), 64'(RST_VEC));
      check_raster(12, 1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/vid_timing_out.md
Name: vid_timing_out

Overview:
- Display back-end stage that sits directly downstream of the video controller's RGB fetch path.
- Pops 24-bit pixels from the pixel FIFO that the fetch path fills, and generates the hsync/hblank/vsync/vblank raster from the programmed h1/h2/v1/v2 timing fields and the cr.pcnt divider.
- Drives registered R/G/B to the display.
- Flags FIFO underflow during active video.

Parameters:
- CW, 13, width of the horizontal/vertical position counters and of the timing fields.
- PW, 6, width of the pixel divider field (cr.pcnt).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  cr.en; start/stop of raster generation
- pcnt  in  PW  pixel divider; one pixel tick every pcnt+1 clocks
- hsize  in  CW  displayed pixels per line
- hend  in  CW  total pixels per line
- hsync_start  in  CW  hcnt at which hsync asserts
- hsync_end  in  CW  hcnt at which hsync deasserts
- vsize  in  CW  displayed lines per frame
- vend  in  CW  total lines per frame
- vsync_start  in  CW  vcnt at which vsync asserts
- vsync_end  in  CW  vcnt at which vsync deasserts
- fifo_rdata  in  24  head of the pixel FIFO {R,G,B}, first-word-fall-through
- fifo_empty  in  1  pixel FIFO empty
- fifo_rd  out  1  pop strobe, one clock wide
- hsync  out  1  active-high horizontal sync
- hblank  out  1  horizontal blank
- vsync  out  1  active-high vertical sync
- vblank  out  1  vertical blank
- R  out  8  red
- G  out  8  green
- B  out  8  blue
- frame_start  out  1  one-clock pulse when position (0,0) is entered
- underflow  out  1  sticky underflow flag

Behaviour:
- Reset (async, active-high):
  - state=IDLE; hcnt=vcnt=0; divider=0.
  - All outputs 0, except hblank=vblank=1.
- Pixel tick:
  - The divider counts 0..pcnt; tick is asserted when divider==pcnt.
  - pcnt=0 gives a tick every clock.
  - The divider runs only in RUN.
- Counters, advanced on tick:
  - hcnt counts 0..hend-1 and wraps to 0; on the wrap, vcnt increments.
  - vcnt counts 0..vend-1 and wraps to 0.
  - hend=0 or vend=0 is treated as 1.
- Decode (from the position just entered, registered on the same tick edge, so outputs hold for one pixel period):
  - hblank = hcnt>=hsize; vblank = vcnt>=vsize.
  - hsync = hsync_start<=hcnt<hsync_end; vsync = vsync_start<=vcnt<vsync_end.
  - Comparisons are unsigned, CW bits. start>=end gives a sync that never asserts.
  - active = !hblank && !vblank.
- Pixel path:
  - fifo_rd is combinational: tick && next position active && !fifo_empty.
  - On that edge, {R,G,B} <= fifo_rdata.
  - If the next position is active and the FIFO is empty: {R,G,B} <= 0, underflow <= 1, no pop.
  - In blank regions, {R,G,B} <= 0 and there is no pop.
- State machine:
  - IDLE: outputs held at reset values. Moves to PRIME when enable=1.
  - PRIME: waits for !fifo_empty, then moves to RUN with hcnt=vcnt=0 and the divider cleared.
    - The first tick occurs pcnt+1 clocks after entering RUN.
    - frame_start pulses on the RUN entry edge.
  - RUN: raster free-runs. frame_start pulses on every tick that wraps to (0,0).
    - If enable=0 on the tick that completes the last pixel of the frame (hcnt=hend-1, vcnt=vend-1), go to IDLE with outputs returning to reset values.
    - Deasserting enable mid-frame takes effect only at frame end.
- underflow: sticky in RUN; cleared on reset or on IDLE->PRIME.
- Timing-field changes are taken live. Software programs them with enable=0; behaviour when they change in RUN is unspecified beyond staying in range (counters wrap when >= the new end value).
- Reset asserted mid-frame: immediate return to IDLE; FIFO contents are the fetch side's responsibility.

Decomposition:
- vid_pkg holds:
  - h1/h2/v1/v2/cr packed typedefs.
  - Register offset constants: 0x00, 0x28, 0x30, 0x38, 0x40, 0x48, 0x50.
  - Bus cmd encodings.
  - CW and PW defaults.
  - The state enum {IDLE, PRIME, RUN}.
- One sub-module: vid_pix_div (programmable tick divider with clear).

Test Plan:
- hsize=4, hend=6, hsync 4..5, vsize=2, vend=3, vsync 2..3, pcnt=0, FIFO preloaded with 0x000001 upward.
  - Required: period is 6 clocks per line and 18 clocks per frame.
  - hsync is high for 1 clock per line at hcnt 4; vsync is high for the 6 clocks of line 2.
  - RGB for (0,0)..(3,0) is 0x000001..0x000004; 8 pops per frame.
- Same timing with pcnt=2 -> every output level holds 3 clocks; fifo_rd is a single-clock pulse per active pixel.
- FIFO empty at pixel (2,1) -> RGB=0 for that pixel, underflow=1 and remains set; next pixel pops normally once data returns.
- enable dropped at (1,0) -> raster completes to (5,2), then IDLE with hblank=vblank=1, RGB=0, no further pops.
- enable=1 with FIFO empty for 10 clocks -> stays in PRIME with no sync activity; frame_start pulses 1 clock after the first non-empty.
- Async reset asserted mid-line (between clock edges) -> outputs reach their reset values immediately, without waiting for a clock edge; after release with enable=1, a fresh frame starts at (0,0).
